// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-slave register bank.
//   spi_state_e     : frame decoder FSM states
//   SPI_WRITE/READ  : value of the R/W command bit
//   SPI_REG_SLICE   : part-select of register i (width w) inside a packed register vector

`ifndef SPI_REG_SLICE
`define SPI_REG_SLICE(i, w) (i)*(w) +: (w)
`endif

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } spi_state_e;

    localparam logic SPI_WRITE = 1'b1;
    localparam logic SPI_READ  = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Single-bit synchroniser with edge detection.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised level (last synchroniser stage)
//   rise     : one-clk pulse on a synchronised 0->1 transition
//   fall     : one-clk pulse on a synchronised 1->0 transition
// RST_VAL is the idle level the chain holds in reset, so no edge is reported
// while the input sits at its idle level after reset.

module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            q_d   <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank with read-back.
//   clk, rst   : system clock, asynchronous active-high reset
//   sclk, copi : SPI clock / data in (asynchronous to clk)
//   ncs        : SPI chip select, active-low (asynchronous to clk)
//   cipo       : read data out, MSB first
//   cipo_oe    : high while a read data phase is active
//   regs_o     : register contents, register i at [i*DATA_W +: DATA_W]
//   wr_strobe  : one-clk pulse on the register that was written
//   frame_err  : one-clk pulse on an aborted frame or out-of-range address
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.

module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned       NUM_REGS    = 5,
    parameter int unsigned       ADDR_W      = 7,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int unsigned CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned ARM_N   = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_N + 1);
    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d(copi), .q(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(ncs), .q(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, copi_rise, copi_fall, sclk_lvl};

    // ------------------------------------------------------------------
    // Frame arming: the ncs chain resets to idle-high, so if ncs is already
    // low when rst is released (reset mid-frame) the chain would later show a
    // false fall. A frame may only start after ncs has been seen high for
    // longer than the chain depth.
    // ------------------------------------------------------------------
    logic             armed;
    logic [ARM_W-1:0] arm_cnt;
    logic             frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (!ncs_lvl) begin
                arm_cnt <= '0;
            end else if (arm_cnt == ARM_W'(ARM_N - 1)) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign frame_start = ncs_fall & armed;

    // ------------------------------------------------------------------
    // Datapath registers and helpers
    // ------------------------------------------------------------------
    spi_state_e        state, next_state;
    logic              rw;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] rx_q, tx_q, tx_shift, rd_word;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              addr_ok, addr_next_ok;
    logic              last_bit;

    always_comb begin
        addr_next    = (addr_q << 1) | ADDR_W'(copi_lvl);
        addr_ok      = {1'b0, addr_q} < NUM_REGS_X;
        addr_next_ok = {1'b0, addr_next} < NUM_REGS_X;
        rd_word      = addr_next_ok ? regs[addr_next[IDX_W-1:0]] : '0;
        tx_shift     = tx_q << 1;
        last_bit     = (bit_cnt == CNT_W'(1));
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = regs[g];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (ncs_rise) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                // An sclk rise coinciding with the ncs fall is already bit0.
                ST_IDLE: if (frame_start) next_state = sclk_rise ? ST_ADDR : ST_CMD;
                ST_CMD:  if (sclk_rise) next_state = ST_ADDR;
                ST_ADDR: if (sclk_rise && last_bit) next_state = ST_DATA;
                ST_DATA: if (sclk_rise && last_bit) next_state = ST_DONE;
                ST_DONE: next_state = ST_DONE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shift registers, counters, register array, strobes and errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw        <= SPI_READ;
            addr_q    <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            bit_cnt   <= '0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;

            if (ncs_rise) begin
                cipo    <= 1'b0;
                cipo_oe <= 1'b0;
                if (state == ST_DONE) begin
                    if (!addr_ok) begin
                        frame_err <= 1'b1;
                    end else if (rw == SPI_WRITE) begin
                        regs[addr_q[IDX_W-1:0]]      <= rx_q;
                        wr_strobe[addr_q[IDX_W-1:0]] <= 1'b1;
                    end
                end else if (state != ST_IDLE) begin
                    frame_err <= 1'b1;
                end
            end else if (next_state == ST_ADDR && state != ST_ADDR) begin
                rw      <= copi_lvl;
                addr_q  <= '0;
                bit_cnt <= CNT_W'(ADDR_W);
            end else if (state == ST_ADDR && sclk_rise) begin
                addr_q <= addr_next;
                if (last_bit) begin
                    bit_cnt <= CNT_W'(DATA_W);
                    rx_q    <= '0;
                    if (rw == SPI_READ) begin
                        tx_q    <= rd_word;
                        cipo    <= rd_word[DATA_W-1];
                        cipo_oe <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt - CNT_W'(1);
                end
            end else if (state == ST_DATA) begin
                if (sclk_rise) begin
                    rx_q    <= (rx_q << 1) | DATA_W'(copi_lvl);
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (last_bit) begin
                        cipo    <= 1'b0;
                        cipo_oe <= 1'b0;
                    end
                end else if (sclk_fall && cipo_oe && bit_cnt != CNT_W'(DATA_W)) begin
                    // The fall right after the last address bit precedes the
                    // sampling of the MSB, so shifting starts one fall later.
                    tx_q <= tx_shift;
                    cipo <= tx_shift[DATA_W-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default instance (5 x 8-bit, 7-bit address)
// and a 16 x 16-bit instance with 4-bit address sharing sclk/copi/rst.

module tb_spi_reg_bank;

    logic clk = 1'b0;
    logic rst;
    logic sclk, copi, ncs_a, ncs_b;

    logic        cipo_a, cipo_oe_a, frame_err_a;
    logic [39:0] regs_a;
    logic [4:0]  stb_a;

    logic         cipo_b, cipo_oe_b, frame_err_b;
    logic [255:0] regs_b;
    logic [15:0]  stb_b;

    always #5 clk = ~clk;

    spi_reg_bank dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs_a),
        .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_o(regs_a),
        .wr_strobe(stb_a), .frame_err(frame_err_a)
    );

    spi_reg_bank #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut_b (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs_b),
        .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_o(regs_b),
        .wr_strobe(stb_b), .frame_err(frame_err_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse monitor: cycles with any strobe / frame error high, last strobe seen.
    int          stb_cycles  = 0;
    int          ferr_cycles = 0;
    logic [15:0] stb_last    = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (stb_a != '0 || stb_b != '0) begin
                stb_cycles = stb_cycles + 1;
                stb_last   = {11'b0, stb_a} | stb_b;
            end
            if (frame_err_a || frame_err_b) ferr_cycles = ferr_cycles + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] reg_of(input bit b, input int idx);
        if (b) return regs_b[idx*16 +: 16];
        return {8'h00, regs_a[idx*8 +: 8]};
    endfunction

    // Drives one frame of nbits (MSB of the right-aligned frame first), sampling
    // cipo/cipo_oe just before every sclk rise. rst_at >= 0 pulses rst before that bit.
    task automatic spi_xfer(input bit b, input logic [31:0] frame, input int nbits,
                            input int rst_at, output logic [15:0] rd, output int oe_cnt);
        int aw, dw;
        aw     = b ? 4 : 7;
        dw     = b ? 16 : 8;
        rd     = '0;
        oe_cnt = 0;
        if (b) ncs_b = 1'b0; else ncs_a = 1'b0;
        clks(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                clks(3);
                rst = 1'b0;
                clks(2);
            end
            copi = frame[nbits-1-i];
            clks(8);
            if (i >= 1 + aw && i < 1 + aw + dw) rd = {rd[14:0], (b ? cipo_b : cipo_a)};
            if (b ? cipo_oe_b : cipo_oe_a) oe_cnt++;
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
        clks(8);
        ncs_a = 1'b1;
        ncs_b = 1'b1;
        clks(12);
    endtask

    typedef struct {
        string       name;
        bit          dut_b;
        int          nbits;
        logic [31:0] frame;
        logic [15:0] exp_rd;
        int          exp_oe;
        logic [15:0] exp_stb;
        int          exp_ferr;
        int          chk_idx;
        logic [15:0] exp_reg;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0] rd;
        int          oe_cnt, stb0, ferr0;

        vecs[0]  = '{"w0_a5",    0, 16, 32'h80A5,   16'h0000, 0,  16'h0001, 0, 0,  16'h00A5};
        vecs[1]  = '{"w4_3c",    0, 16, 32'h843C,   16'h0000, 0,  16'h0010, 0, 4,  16'h003C};
        vecs[2]  = '{"r4",       0, 16, 32'h0400,   16'h003C, 8,  16'h0000, 0, 4,  16'h003C};
        vecs[3]  = '{"w5_oor",   0, 16, 32'h85FF,   16'h0000, 0,  16'h0000, 1, 4,  16'h003C};
        vecs[4]  = '{"w2_short", 0, 13, 32'h1055,   16'h0000, 0,  16'h0000, 1, 2,  16'h0000};
        vecs[5]  = '{"w2_11",    0, 16, 32'h8211,   16'h0000, 0,  16'h0004, 0, 2,  16'h0011};
        vecs[6]  = '{"r6_oor",   0, 16, 32'h0600,   16'h0000, 8,  16'h0000, 1, 0,  16'h00A5};
        vecs[7]  = '{"r0",       0, 16, 32'h0000,   16'h00A5, 8,  16'h0000, 0, 0,  16'h00A5};
        vecs[8]  = '{"r_short",  0, 5,  32'h0000,   16'h0000, 0,  16'h0000, 1, 4,  16'h003C};
        vecs[9]  = '{"w1_long",  0, 20, 32'h815AF,  16'h0000, 0,  16'h0002, 0, 1,  16'h005A};
        vecs[10] = '{"b_w15",    1, 21, 32'h1FBEEF, 16'h0000, 0,  16'h8000, 0, 15, 16'hBEEF};
        vecs[11] = '{"b_r15",    1, 21, 32'h0F0000, 16'hBEEF, 16, 16'h0000, 0, 15, 16'hBEEF};

        rst   = 1'b1;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs_a = 1'b1;
        ncs_b = 1'b1;
        clks(4);

        check("rst_regs_a",  {24'b0, regs_a}, 64'h0);
        check("rst_regs_b",  {63'b0, (regs_b == '0)}, 64'h1);
        check("rst_cipo",    {62'b0, cipo_a, cipo_b}, 64'h0);
        check("rst_cipo_oe", {62'b0, cipo_oe_a, cipo_oe_b}, 64'h0);
        check("rst_strobe",  {43'b0, stb_a, stb_b}, 64'h0);
        check("rst_ferr",    {62'b0, frame_err_a, frame_err_b}, 64'h0);

        rst = 1'b0;
        clks(10);

        for (int v = 0; v < 12; v++) begin
            stb0  = stb_cycles;
            ferr0 = ferr_cycles;
            spi_xfer(vecs[v].dut_b, vecs[v].frame, vecs[v].nbits, -1, rd, oe_cnt);
            check({vecs[v].name, "_oe_bits"}, 64'(oe_cnt), 64'(vecs[v].exp_oe));
            if (vecs[v].exp_oe != 0) check({vecs[v].name, "_rd"}, {48'b0, rd}, {48'b0, vecs[v].exp_rd});
            check({vecs[v].name, "_stb_cycles"}, 64'(stb_cycles - stb0), 64'((vecs[v].exp_stb != '0) ? 1 : 0));
            if (vecs[v].exp_stb != '0) check({vecs[v].name, "_stb"}, {48'b0, stb_last}, {48'b0, vecs[v].exp_stb});
            check({vecs[v].name, "_ferr_cycles"}, 64'(ferr_cycles - ferr0), 64'(vecs[v].exp_ferr));
            check({vecs[v].name, "_reg"}, {48'b0, reg_of(vecs[v].dut_b, vecs[v].chk_idx)}, {48'b0, vecs[v].exp_reg});
        end

        // Whole-bank snapshot after the table: r0=A5, r1=5A, r2=11, r3=00, r4=3C.
        check("bank_a_after_table", {24'b0, regs_a}, {24'b0, 40'h3C_00_11_5A_A5});

        // Reset in the middle of the data phase of a write 0x77 to reg1.
        stb0  = stb_cycles;
        ferr0 = ferr_cycles;
        spi_xfer(1'b0, 32'h8177, 16, 11, rd, oe_cnt);
        check("midrst_regs_a",     {24'b0, regs_a}, 64'h0);
        check("midrst_regs_b",     {63'b0, (regs_b == '0)}, 64'h1);
        check("midrst_stb_cycles", 64'(stb_cycles - stb0), 64'h0);
        check("midrst_ferr",       64'(ferr_cycles - ferr0), 64'h0);

        // The next frame must decode normally.
        stb0  = stb_cycles;
        ferr0 = ferr_cycles;
        spi_xfer(1'b0, 32'h8233, 16, -1, rd, oe_cnt);
        check("postrst_regs_a",     {24'b0, regs_a}, {24'b0, 40'h00_00_33_00_00});
        check("postrst_stb_cycles", 64'(stb_cycles - stb0), 64'h1);
        check("postrst_stb",        {48'b0, stb_last}, 64'h0004);
        check("postrst_ferr",       64'(ferr_cycles - ferr0), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
